// File: rtl/if_fetch_unit_pkg.sv
// Shared constants, entry layout and fault check for the instruction fetch unit.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
package if_fetch_unit_pkg;

    localparam logic [31:0] ResetPcDefault = 32'h0000_3000;
    localparam logic [31:0] ImBaseDefault  = 32'h0000_3000;
    localparam logic [31:0] NopInstr       = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } fetch_entry_t;

    localparam int unsigned EntryW = $bits(fetch_entry_t);

    // Misaligned, below the IM window, or at/after its end.
    function automatic logic fetch_fault(input logic [31:0] pc, input logic [31:0] base,
                                         input logic [31:0] win_bytes);
        logic [31:0] off;
        off = pc - base;
        return (pc[1:0] != 2'b00) || (pc < base) || (off >= win_bytes);
    endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Prefetch FIFO: Depth x Width synchronous storage with push, pop, flush and occupancy count.
// Flush takes priority over push/pop; reset also clears the storage.
module if_fetch_unit_fetch_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 65,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            cnt_d = cnt_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from IM, queues {pc, instr, err} for decode.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt / flush_cnt performance counter ports.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ResetPcDefault,
    parameter logic [31:0] IM_BASE  = ImBaseDefault,
    parameter int unsigned IM_WORDS = 1024,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] im_pc,
    input  logic [31:0] im_ir,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int unsigned CntW     = $clog2(DEPTH) + 1;
    localparam logic [31:0] WinBytes = 32'(IM_WORDS * 4);

    logic [31:0]     pc_q, pc_d;
    logic            halted_q, halted_d;
    logic [CntW-1:0] count;
    logic            deq, fetch, err;
    fetch_entry_t    push_entry, head_entry;

    assign deq   = out_valid & out_ready;
    assign err   = fetch_fault(pc_q, IM_BASE, WinBytes);
    assign fetch = !halted_q && !redirect_valid && ((count < CntW'(DEPTH)) || deq);

    always_comb begin
        push_entry.pc    = pc_q;
        push_entry.instr = err ? NopInstr : im_ir;
        push_entry.err   = err;
    end

    // Redirect overrides everything; a faulting fetch parks the PC until redirect or reset.
    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            halted_d = 1'b0;
        end else if (fetch) begin
            if (err) halted_d = 1'b1;
            else     pc_d     = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    if_fetch_unit_fetch_fifo #(
        .Depth (DEPTH),
        .Width (EntryW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (fetch),
        .pop_i   (deq),
        .flush_i (redirect_valid),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .count_o (count)
    );

    assign im_pc     = pc_q;
    assign out_valid = (count != '0);
    assign out_pc    = head_entry.pc;
    assign out_instr = head_entry.instr;
    assign out_err   = head_entry.err;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // A head consumed in the redirect cycle is a completed transfer, not a discard.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(fetch);
        flush_cnt_d = flush_cnt_q;
        if (redirect_valid) flush_cnt_d = flush_cnt_q + 32'(count) - 32'(deq);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic against a queue-based model.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int unsigned IM_WORDS = 1024;
    localparam int unsigned DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] im_pc, im_ir;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr;
    logic        out_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC (RESET_PC),
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .im_pc          (im_pc),
        .im_ir          (im_ir),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_err        (out_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    // Instruction memory; outside the window it returns junk that must never reach decode.
    logic [31:0] mem [IM_WORDS];

    always_comb begin
        logic [31:0] off;
        off = im_pc - IM_BASE;
        if (im_pc[1:0] == 2'b00 && im_pc >= IM_BASE && off < 32'(IM_WORDS * 4))
            im_ir = mem[off[11:2]];
        else
            im_ir = 32'hDEAD_BEEF;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_live;
    bit          m_just_reset;
    logic [31:0] m_fetch_cnt, m_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_fault(input logic [31:0] p);
        longint lp;
        lp = longint'(p);
        return (lp % 4 != 0) || (lp < longint'(IM_BASE)) ||
               (lp >= longint'(IM_BASE) + 4 * longint'(IM_WORDS));
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] p);
        longint idx;
        idx = (longint'(p) - longint'(IM_BASE)) / 4;
        return mem[int'(idx)];
    endfunction

    // One cycle: check current outputs against the model, drive inputs, advance the model.
    task automatic step(input bit rst_n, input bit rv, input logic [31:0] rpc, input bit rdy);
        int  sz;
        bit  deq, fetch;
        ent_t e;
        @(negedge clk);
        if (m_live) begin
            check_eq("im_pc", im_pc, m_pc);
            check_eq("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check_eq("out_pc", out_pc, m_q[0].pc);
                check_eq("out_instr", out_instr, m_q[0].instr);
                check_eq("out_err", 32'(out_err), 32'(m_q[0].err));
            end else if (m_just_reset) begin
                check_eq("rst_out_pc", out_pc, 32'h0);
                check_eq("rst_out_instr", out_instr, 32'h0);
                check_eq("rst_out_err", 32'(out_err), 32'h0);
            end
`ifdef FETCH_PERF_CNT_EN
            check_eq("fetch_cnt", fetch_cnt, m_fetch_cnt);
            check_eq("flush_cnt", flush_cnt, m_flush_cnt);
`endif
        end
        reset          = rst_n;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;

        sz  = m_q.size();
        deq = (sz != 0) && rdy;
        m_just_reset = 1'b0;
        if (!rst_n) begin
            m_q.delete();
            m_pc         = RESET_PC;
            m_halted     = 1'b0;
            m_fetch_cnt  = '0;
            m_flush_cnt  = '0;
            m_live       = 1'b1;
            m_just_reset = 1'b1;
        end else if (rv) begin
            m_flush_cnt = m_flush_cnt + 32'(sz) - 32'(deq);
            m_q.delete();
            m_pc     = rpc;
            m_halted = 1'b0;
        end else begin
            if (deq) void'(m_q.pop_front());
            fetch = !m_halted && (sz < int'(DEPTH) || deq);
            if (fetch) begin
                e.pc    = m_pc;
                e.err   = ref_fault(m_pc);
                e.instr = e.err ? 32'h0 : ref_word(m_pc);
                m_q.push_back(e);
                m_fetch_cnt = m_fetch_cnt + 1;
                if (e.err) m_halted = 1'b1;
                else       m_pc = m_pc + 32'd4;
            end
        end
    endtask

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 5))
            0: return IM_BASE + 32'(4 * $urandom_range(0, IM_WORDS - 1));
            1: return IM_BASE + 32'(4 * IM_WORDS) - 32'(4 * $urandom_range(1, 4));
            2: return IM_BASE + 32'(4 * $urandom_range(0, IM_WORDS - 1)) + 32'($urandom_range(1, 3));
            3: return 32'h0000_1000;
            4: return 32'hFFFF_FFF8;
            default: return IM_BASE + 32'(4 * $urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < int'(IM_WORDS); i++) mem[i] = 32'(i + 1);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        m_live         = 1'b0;
        m_just_reset   = 1'b0;
        m_pc           = RESET_PC;
        m_halted       = 1'b0;
        m_fetch_cnt    = '0;
        m_flush_cnt    = '0;

        // Reset for two cycles, then release with decode ready.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("rst_im_pc", im_pc, 32'h0000_3000);
        check_eq("rst_valid", 32'(out_valid), 32'h0);

        // Stall decode: FIFO fills, PC freezes at 0x3008, head holds 0x3000.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("stall_im_pc", im_pc, 32'h0000_3008);
        check_eq("stall_out_pc", out_pc, 32'h0000_3000);

        // Redirect with full FIFO and a same-cycle dequeue.
        step(1'b1, 1'b1, 32'h0000_3100, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("redir_im_pc", im_pc, 32'h0000_3100);
        check_eq("redir_empty", 32'(out_valid), 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("redir_out_pc", out_pc, 32'h0000_3100);

        // Misaligned target: single faulting entry, then the unit stays halted.
        step(1'b1, 1'b1, 32'h0000_3102, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("halt_im_pc", im_pc, 32'h0000_3102);
        check_eq("halt_err", 32'(out_err), 32'h1);
        step(1'b1, 1'b1, 32'h0000_3000, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Run off the end of the IM window.
        step(1'b1, 1'b1, 32'h0000_3FF0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("eow_im_pc", im_pc, 32'h0000_4000);

        // Reset while the FIFO is full and fetching is live.
        step(1'b1, 1'b1, 32'h0000_3000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("midrst_valid", 32'(out_valid), 32'h0);
        check_eq("midrst_im_pc", im_pc, 32'h0000_3000);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            bit rst_n, rv, rdy;
            rst_n = ($urandom_range(0, 149) != 0);
            rv    = ($urandom_range(0, 11) == 0);
            rdy   = ($urandom_range(0, 9) < 7);
            step(rst_n, rv, rv ? rand_target() : 32'($urandom), rdy);
        end
        step(1'b1, 1'b0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: owns the PC, drives the word address into IM and captures the returned instruction word.
- Buffers fetched {pc, instr, err} entries in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from later stages, which flush the FIFO.
- Sits between IM and the decode stage.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, byte address of IM word 0.
- IM_WORDS, 1024, IM depth in 32-bit words; legal window is [IM_BASE, IM_BASE+4*IM_WORDS).
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- im_pc  out  32  current fetch PC to IM; IM returns im_ir combinationally in the same cycle.
- im_ir  in  32  instruction word from IM.
- redirect_valid  in  1  redirect request.
- redirect_pc  in  32  redirect target.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  32  PC of head entry.
- out_instr  out  32  instruction of head entry.
- out_err  out  1  head entry is a fetch fault (misaligned or out of window).

Behaviour:
- Reset (reset==0 at posedge): pc←RESET_PC, FIFO count←0, pointers←0, halted←0, all entry storage cleared. Outputs follow: out_valid=0, out_pc=0, out_instr=0, out_err=0, im_pc=RESET_PC. Reset mid-operation discards all entries and any pending redirect.
- im_pc = pc at all times. No other state drives it.
- Handshake:
  - deq = out_valid & out_ready.
  - out_valid = (count≠0).
  - out_* show the head entry and hold stable while out_valid & !out_ready.
- Fetch condition: fetch = !halted & !redirect_valid & (count<DEPTH | deq).
- On fetch:
  - Push {pc, instr, err}, where err = (pc[1:0]≠0) | (pc<IM_BASE) | (pc−IM_BASE ≥ 4*IM_WORDS).
  - instr = err ? 32'h0 : im_ir.
  - If err: halted←1 and pc holds. Otherwise pc←pc+4, 32-bit wrap (0xFFFF_FFFC+4 = 0, which is out of window and faults on the next fetch).
- Throughput: one fetch per cycle when decode keeps out_ready=1. Latency from PC to out_valid is 1 cycle.
- Full FIFO: deq and fetch in the same cycle keep count unchanged. Full without deq stalls pc.
- Empty: out_valid=0. out_ready is ignored.
- Redirect (highest priority):
  - Next cycle: count←0, pointers←0, halted←0, pc←redirect_pc, with no push.
  - A deq in the same cycle is a completed transfer (decode consumed the head); the remaining entries are discarded.
  - redirect_pc is not checked at redirect time; a bad target faults on its first fetch.
- Halted state: exited only by redirect or reset. FIFO contents still drain normally.
- Count arithmetic: count is $clog2(DEPTH)+1 bits, next count = count + push − deq. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds ports fetch_cnt out 32 and flush_cnt out 32, both 0 on reset.
  - fetch_cnt +1 per push.
  - flush_cnt + (count − deq) per redirect cycle, i.e. entries discarded.
  - Both counters wrap at 2^32.
- Undefined: ports and counter logic are absent; remaining behaviour is identical.

Decomposition:
- Shared package (Macro.v include): RESET_PC / IM_BASE default constants, NOP word 32'h0, and the FETCH_PERF_CNT_EN macro guard.
- One natural sub-module, fetch_fifo: a parameterised DEPTH × 65-bit synchronous FIFO with push/pop/flush and count. The top holds the pc register, halt flag, fault check and perf counters.

Test Plan:
- Reset held 2 cycles, then released with out_ready=1 and IM preloaded 0x00000001.. → im_pc steps 0x3000, 0x3004, … one per cycle; first out_valid one cycle after release with out_pc=0x3000, out_instr=word0, out_err=0.
- out_ready=0 for 5 cycles → count saturates at 2, im_pc freezes at 0x3008, out_pc holds 0x3000. Then out_ready=1 → 0x3000, 0x3004, 0x3008 in consecutive cycles with no bubble.
- Full FIFO, redirect_valid=1 with redirect_pc=0x3100 and out_ready=1 in the same cycle → head 0x3000 consumed, next entry flushed, next cycle im_pc=0x3100, following cycle out_pc=0x3100. With FETCH_PERF_CNT_EN, flush_cnt=1.
- Redirect to 0x3102 → one entry with out_err=1, out_instr=0, out_pc=0x3102; im_pc stays 0x3102 and no further pushes for 10 cycles. Redirect to 0x3000 resumes fetching.
- Sequential fetch running to PC 0x3FFC → entry 0x3FFC has err=0; entry 0x4000 has err=1 (out of window) and the unit halts.
- reset=0 asserted while count=2 and halted=0 → next cycle out_valid=0, im_pc=0x3000, counters 0; normal fetch resumes after release.
